// File: rtl/coreb_pkg.sv
// Core-B shared definitions: transfer size codes, slave FSM states, data widths.
`timescale 1ns/1ps
package coreb_pkg;

  localparam int unsigned SB_W = 7;
  localparam int unsigned DW   = 32;

  localparam logic [2:0] SZ_BYTE = 3'b000;
  localparam logic [2:0] SZ_HALF = 3'b001;
  localparam logic [2:0] SZ_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_t;

endpackage

// File: rtl/coreb_slave_port_if.sv
// Core-B slave port bundle: bus-side transfer signals plus the register-access port.
`timescale 1ns/1ps
interface coreb_slave_port_if #(
  parameter int unsigned ADDR_W = 8
);
  import coreb_pkg::*;

  // bus side
  logic                 DSEL;
  logic                 MsRDY;
  logic                 MmWT;
  logic [2:0]           MmSZ;
  logic [31:0]          MmADDR;
  logic [SB_W+DW-1:0]   MmWDT;
  logic                 SRDY;
  logic                 SERR;
  logic [SB_W+DW-1:0]   SRDT;

  // register-access side
  logic                 RegReq;
  logic                 RegWr;
  logic [ADDR_W-3:0]    RegAddr;
  logic [3:0]           RegBE;
  logic [DW-1:0]        RegWDT;
  logic [DW-1:0]        RegRDT;
  logic                 RegAck;
  logic                 RegErr;

  modport slave (
    input  DSEL, MsRDY, MmWT, MmSZ, MmADDR, MmWDT, RegRDT, RegAck, RegErr,
    output SRDY, SERR, SRDT, RegReq, RegWr, RegAddr, RegBE, RegWDT
  );

  modport master (
    output DSEL, MsRDY, MmWT, MmSZ, MmADDR, MmWDT, RegRDT, RegAck, RegErr,
    input  SRDY, SERR, SRDT, RegReq, RegWr, RegAddr, RegBE, RegWDT
  );

endinterface

// File: rtl/coreb_be_gen.sv
// Byte-enable generation and illegal-size / misalignment detection for one transfer.
`timescale 1ns/1ps
module coreb_be_gen
  import coreb_pkg::*;
(
  input  logic [2:0] sz,
  input  logic [1:0] lo,
  output logic [3:0] be,
  output logic       bad
);

  // decode size and low address bits into lane enables and an error flag
  always_comb begin
    be  = '0;
    bad = 1'b0;
    case (sz)
      SZ_BYTE: be = 4'b0001 << lo;
      SZ_HALF: begin
        be  = lo[1] ? 4'b1100 : 4'b0011;
        bad = lo[0];
      end
      SZ_WORD: begin
        be  = '1;
        bad = |lo;
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/coreb_slave_port.sv
// Core-B slave responder: turns bus transfers into a req/ack register-access port,
// with size/alignment checking, a two-cycle error response and an ack timeout.
`timescale 1ns/1ps
module coreb_slave_port
  import coreb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  coreb_slave_port_if.slave bus
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t            state;
  logic              srdy_q;
  logic              serr_q;
  logic              req_q;
  logic              wr_q;
  logic [ADDR_W-3:0] addr_q;
  logic [3:0]        be_q;
  logic [DW-1:0]     rdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W:0]    cnt_inc;
  logic [3:0]        be_nxt;
  logic              bad_nxt;
  logic              accept;
  logic              timeout_hit;
  logic              unused_bits;

  coreb_be_gen u_be_gen (
    .sz  (bus.MmSZ),
    .lo  (bus.MmADDR[1:0]),
    .be  (be_nxt),
    .bad (bad_nxt)
  );

  assign accept      = bus.DSEL & bus.MsRDY;
  assign cnt_inc     = {1'b0, cnt_q} + 1'b1;
  // expiry is judged on the incremented count so RegReq stays high exactly TIMEOUT cycles
  assign timeout_hit = (TIMEOUT != 0) && (32'(cnt_inc) == TIMEOUT);

  assign bus.SRDY    = srdy_q;
  assign bus.SERR    = serr_q;
  assign bus.SRDT    = {{SB_W{1'b0}}, rdata_q};
  assign bus.RegReq  = req_q;
  assign bus.RegWr   = wr_q;
  assign bus.RegAddr = addr_q;
  assign bus.RegBE   = be_q;
  assign bus.RegWDT  = bus.MmWDT[DW-1:0];

  assign unused_bits = ^{bus.MmADDR, bus.MmWDT[SB_W+DW-1:DW]};

  // transfer FSM with registered bus and register-port outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= ST_IDLE;
      srdy_q  <= 1'b1;
      serr_q  <= 1'b0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR2: begin
          if (accept) begin
            wr_q   <= bus.MmWT;
            addr_q <= bus.MmADDR[ADDR_W-1:2];
            be_q   <= be_nxt;
            cnt_q  <= '0;
            if (bad_nxt) begin
              state  <= ST_ERR1;
              srdy_q <= 1'b0;
              serr_q <= 1'b1;
              req_q  <= 1'b0;
            end else begin
              state  <= ST_ACCESS;
              srdy_q <= 1'b0;
              serr_q <= 1'b0;
              req_q  <= 1'b1;
            end
          end else begin
            state  <= ST_IDLE;
            srdy_q <= 1'b1;
            serr_q <= 1'b0;
            req_q  <= 1'b0;
          end
        end
        // ack is checked before the timeout so a same-cycle ack completes normally
        ST_ACCESS: begin
          if (bus.RegAck) begin
            req_q <= 1'b0;
            if (bus.RegErr) begin
              state  <= ST_ERR1;
              srdy_q <= 1'b0;
              serr_q <= 1'b1;
            end else begin
              state  <= ST_DONE;
              srdy_q <= 1'b1;
              serr_q <= 1'b0;
              if (!wr_q) rdata_q <= bus.RegRDT;
            end
          end else if (timeout_hit) begin
            state  <= ST_ERR1;
            srdy_q <= 1'b0;
            serr_q <= 1'b1;
            req_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_inc[CNT_W-1:0];
          end
        end
        ST_ERR1: begin
          state  <= ST_ERR2;
          srdy_q <= 1'b1;
          serr_q <= 1'b1;
          req_q  <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          srdy_q <= 1'b1;
          serr_q <= 1'b0;
          req_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coreb_slave_port.sv
// Self-checking bench for coreb_slave_port: directed scenarios plus randomized transfers
// checked against a per-transfer behavioural model of the bus response.
`timescale 1ns/1ps
module tb_coreb_slave_port;
  import coreb_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned TO = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_srdt = '0;

  coreb_slave_port_if #(.ADDR_W(AW)) bus ();

  coreb_slave_port #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // expected lane enables / error from the size and address rules
  function automatic void model_be(input logic [2:0] sz, input logic [7:0] a,
                                   output logic [3:0] be, output bit bad);
    int unsigned off;
    off = a % 4;
    be  = 4'h0;
    bad = 1'b0;
    if (sz == 3'd0) begin
      be = 4'(1 << off);
    end else if (sz == 3'd1) begin
      be  = (off >= 2) ? 4'hC : 4'h3;
      bad = (off % 2) != 0;
    end else if (sz == 3'd2) begin
      be  = 4'hF;
      bad = off != 0;
    end else begin
      bad = 1'b1;
    end
  endfunction

  // one transfer, entered and left at posedge+1 of a cycle where SRDY=1
  task automatic xfer(input bit wt, input logic [2:0] sz, input logic [7:0] addr,
                      input logic [31:0] wd, input logic [31:0] rd,
                      input int delay, input bit perr);
    logic [3:0] ebe;
    bit ebad;
    bit acked;
    bit last;
    model_be(sz, addr, ebe, ebad);
    acked = delay < int'(TO);
    bus.DSEL   = 1'b1;
    bus.MsRDY  = 1'b1;
    bus.MmWT   = wt;
    bus.MmSZ   = sz;
    bus.MmADDR = {24'($urandom()), addr};
    bus.MmWDT  = {7'($urandom()), wd};
    tick;
    // address phase is over: scramble it, keep data held, bus mux not ready
    bus.DSEL   = 1'($urandom());
    bus.MsRDY  = 1'b0;
    bus.MmWT   = 1'($urandom());
    bus.MmSZ   = 3'($urandom());
    bus.MmADDR = $urandom();
    if (ebad) begin
      checks++;
      if ({bus.SRDY, bus.SERR, bus.RegReq} !== 3'b010) begin
        failures++;
        $display("FAIL err1_flags: got srdy/serr/req=%b exp 010", {bus.SRDY, bus.SERR, bus.RegReq});
      end
      tick;
      checks++;
      if ({bus.SRDY, bus.SERR, bus.RegReq} !== 3'b110) begin
        failures++;
        $display("FAIL err2_flags: got srdy/serr/req=%b exp 110", {bus.SRDY, bus.SERR, bus.RegReq});
      end
    end else begin
      for (int k = 0; k < int'(TO); k++) begin
        checks++;
        if ({bus.SRDY, bus.SERR, bus.RegReq} !== 3'b001) begin
          failures++;
          $display("FAIL access_flags cyc%0d: got srdy/serr/req=%b exp 001", k, {bus.SRDY, bus.SERR, bus.RegReq});
        end
        checks++;
        if ({bus.RegWr, bus.RegAddr, bus.RegBE, bus.RegWDT} !== {wt, addr[7:2], ebe, wd}) begin
          failures++;
          $display("FAIL access_port cyc%0d: got wr=%b addr=%h be=%b wdt=%h exp wr=%b addr=%h be=%b wdt=%h",
                   k, bus.RegWr, bus.RegAddr, bus.RegBE, bus.RegWDT, wt, addr[7:2], ebe, wd);
        end
        bus.RegAck = (k == delay);
        bus.RegErr = (k == delay) && perr;
        bus.RegRDT = (k == delay) ? rd : $urandom();
        last = (k == delay) || (k == int'(TO) - 1);
        tick;
        bus.RegAck = 1'b0;
        bus.RegErr = 1'b0;
        if (last) break;
      end
      if (acked && !perr) begin
        if (!wt) exp_srdt = rd;
        checks++;
        if ({bus.SRDY, bus.SERR, bus.RegReq} !== 3'b100) begin
          failures++;
          $display("FAIL done_flags: got srdy/serr/req=%b exp 100", {bus.SRDY, bus.SERR, bus.RegReq});
        end
      end else begin
        checks++;
        if ({bus.SRDY, bus.SERR, bus.RegReq} !== 3'b010) begin
          failures++;
          $display("FAIL acc_err1_flags: got srdy/serr/req=%b exp 010", {bus.SRDY, bus.SERR, bus.RegReq});
        end
        tick;
        checks++;
        if ({bus.SRDY, bus.SERR, bus.RegReq} !== 3'b110) begin
          failures++;
          $display("FAIL acc_err2_flags: got srdy/serr/req=%b exp 110", {bus.SRDY, bus.SERR, bus.RegReq});
        end
      end
    end
    checks++;
    if (bus.SRDT !== {7'b0, exp_srdt}) begin
      failures++;
      $display("FAIL srdt: got %h exp %h", bus.SRDT, {7'b0, exp_srdt});
    end
    bus.DSEL  = 1'b0;
    bus.MsRDY = 1'b1;
  endtask

  task automatic go_idle;
    bus.DSEL  = 1'b0;
    bus.MsRDY = 1'b1;
    tick;
    checks++;
    if ({bus.SRDY, bus.SERR, bus.RegReq} !== 3'b100 || bus.SRDT !== {7'b0, exp_srdt}) begin
      failures++;
      $display("FAIL idle: got srdy/serr/req=%b srdt=%h exp 100 srdt=%h",
               {bus.SRDY, bus.SERR, bus.RegReq}, bus.SRDT, {7'b0, exp_srdt});
    end
  endtask

  task automatic test_reset;
    bus.DSEL = 1'b0; bus.MsRDY = 1'b1; bus.MmWT = 1'b0; bus.MmSZ = '0;
    bus.MmADDR = '0; bus.MmWDT = '0; bus.RegRDT = '0; bus.RegAck = 1'b0; bus.RegErr = 1'b0;
    RST = 1'b1;
    tick; tick;
    #4 RST = 1'b0;
    tick;
    checks++;
    if ({bus.SRDY, bus.SERR, bus.RegReq, bus.RegWr, bus.RegAddr, bus.RegBE, bus.SRDT} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 4'd0, 39'd0}) begin
      failures++;
      $display("FAIL reset_values: got srdy=%b serr=%b req=%b wr=%b addr=%h be=%b srdt=%h",
               bus.SRDY, bus.SERR, bus.RegReq, bus.RegWr, bus.RegAddr, bus.RegBE, bus.SRDT);
    end
    exp_srdt = '0;
  endtask

  task automatic test_word_read;
    xfer(1'b0, SZ_WORD, 8'h10, 32'h0, 32'hDEADBEEF, 0, 1'b0);
    go_idle;
  endtask

  task automatic test_byte_write_delayed;
    xfer(1'b1, SZ_BYTE, 8'h06, 32'h00AB0000, 32'h12345678, 2, 1'b0);
    go_idle;
  endtask

  task automatic test_misaligned;
    xfer(1'b0, SZ_HALF, 8'h03, 32'h0, 32'h0, 0, 1'b0);
    go_idle;
    xfer(1'b0, 3'b011, 8'h03, 32'h0, 32'h0, 0, 1'b0);
    go_idle;
    xfer(1'b1, SZ_WORD, 8'h42, 32'h5A5A5A5A, 32'h0, 0, 1'b0);
    go_idle;
  endtask

  task automatic test_back_to_back;
    xfer(1'b0, SZ_WORD, 8'h20, 32'h0, 32'hCAFE0001, 0, 1'b0);
    xfer(1'b0, SZ_HALF, 8'h26, 32'h0, 32'hCAFE0002, 1, 1'b0);
    xfer(1'b0, SZ_HALF, 8'h01, 32'h0, 32'h0, 0, 1'b0);
    xfer(1'b1, SZ_BYTE, 8'hFF, 32'hFF000000, 32'h0, 0, 1'b0);
    go_idle;
  endtask

  task automatic test_timeout;
    xfer(1'b0, SZ_WORD, 8'h30, 32'h0, 32'h11111111, 99, 1'b0);
    go_idle;
    xfer(1'b0, SZ_WORD, 8'h34, 32'h0, 32'h22222222, int'(TO) - 1, 1'b0);
    go_idle;
    xfer(1'b0, SZ_WORD, 8'h38, 32'h0, 32'h33333333, 1, 1'b1);
    go_idle;
  endtask

  task automatic test_ack_ignored;
    bus.RegAck = 1'b1;
    bus.RegErr = 1'($urandom());
    bus.RegRDT = $urandom();
    go_idle;
    bus.RegAck = 1'b0;
    bus.RegErr = 1'b0;
    go_idle;
  endtask

  task automatic test_reset_mid;
    bus.DSEL = 1'b1; bus.MsRDY = 1'b1; bus.MmWT = 1'b0; bus.MmSZ = SZ_WORD;
    bus.MmADDR = 32'h0000_0044;
    tick;
    bus.DSEL = 1'b0; bus.MsRDY = 1'b0;
    checks++;
    if (bus.RegReq !== 1'b1) begin
      failures++;
      $display("FAIL mid_req_before_reset: got %b exp 1", bus.RegReq);
    end
    #2 RST = 1'b1;
    #1;
    exp_srdt = '0;
    checks++;
    if ({bus.SRDY, bus.SERR, bus.RegReq, bus.SRDT} !== {3'b100, 39'd0}) begin
      failures++;
      $display("FAIL mid_reset_async: got srdy/serr/req=%b srdt=%h exp 100 srdt=0",
               {bus.SRDY, bus.SERR, bus.RegReq}, bus.SRDT);
    end
    #2 RST = 1'b0;
    bus.MsRDY = 1'b1;
    go_idle;
    xfer(1'b0, SZ_WORD, 8'h44, 32'h0, 32'h0BADF00D, 1, 1'b0);
    go_idle;
  endtask

  task automatic test_random;
    logic [2:0] sz;
    for (int n = 0; n < 60; n++) begin
      sz = (($urandom_range(0, 4)) >= 3) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      xfer(1'($urandom()), sz, 8'($urandom()), $urandom(), $urandom(),
           int'($urandom_range(0, 5)), $urandom_range(0, 4) == 0);
      if ($urandom_range(0, 1) == 0) go_idle;
    end
    go_idle;
  endtask

  initial begin
    test_reset;
    test_word_read;
    test_byte_write_delayed;
    test_misaligned;
    test_back_to_back;
    test_timeout;
    test_ack_ignored;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
